adder_checker: RTL and testbench

Hardware response checker for the adder datapath: consumes beats of {a, b, cin, sum, cout} from the adder under test over a valid/ready stream, recomputes the expected result, and tallies pass/fail counts per session. The stimulus side feeds operands to the adder and forwards operands plus adder outputs here. Sits beside the adder for on-chip self-test; first mismatch is captured for debug.

---
 rtl/adder_checker_if.sv | 39 +++
 rtl/adder_checker.sv | 242 ++++++++++++++++++++++++
 tb/tb_adder_checker.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_checker_if.sv
// Beat stream from the adder stimulus side into the checker: operands, adder outputs, last marker.
// Latency: none, pure wiring bundle.
// Backpressure: valid/ready; a beat moves only on a cycle where in_valid and in_ready are both high.
interface adder_checker_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [WIDTH-1:0] in_sum;
    logic             in_cout;
    logic             in_last;

    // Stimulus side: drives the beat, observes ready
    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_cin,
        output in_sum,
        output in_cout,
        output in_last,
        input  in_ready
    );

    // Checker side: consumes the beat, drives ready
    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_cin,
        input  in_sum,
        input  in_cout,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/adder_checker.sv
// Adder response checker: recomputes a+b+cin per beat, tallies pass/fail per session, captures first mismatch.
// Latency: a beat accepted on one edge is checked into the counters on the next; done rises two cycles after the last beat.
// Backpressure: in_ready depends on state only (high in RUN); optional ADDER_CHECKER_STOP_ON_FAIL_EN ends a session on first mismatch.
module adder_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    adder_checker_if.slave   beat,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             err_valid,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b,
    output logic             err_cin,
    output logic [WIDTH:0]   err_exp,
    output logic [WIDTH:0]   err_got
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    state_t           state_d;

    // Check stage: the accepted beat with its compare result, consumed by the counters next edge
    logic             stg_vld_q;
    logic             stg_vld_d;
    logic             stg_mis_q;
    logic             stg_mis_d;
    logic [WIDTH-1:0] stg_a_q;
    logic [WIDTH-1:0] stg_b_q;
    logic             stg_cin_q;
    logic [WIDTH:0]   stg_exp_q;
    logic [WIDTH:0]   stg_got_q;

    // Session results
    logic [CNT_W-1:0] pass_cnt_q;
    logic [CNT_W-1:0] pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q;
    logic [CNT_W-1:0] fail_cnt_d;
    logic             err_vld_q;
    logic             err_vld_d;
    logic [WIDTH-1:0] err_a_q;
    logic [WIDTH-1:0] err_a_d;
    logic [WIDTH-1:0] err_b_q;
    logic [WIDTH-1:0] err_b_d;
    logic             err_cin_q;
    logic             err_cin_d;
    logic [WIDTH:0]   err_exp_q;
    logic [WIDTH:0]   err_exp_d;
    logic [WIDTH:0]   err_got_q;
    logic [WIDTH:0]   err_got_d;

    logic             accept;
    logic             start_ok;
    logic             abort;
    logic [WIDTH:0]   exp_val;
    logic [WIDTH:0]   got_val;

    // Handshake, session-open qualification and the reference adder
    always_comb begin
        accept   = beat.in_valid & beat.in_ready;
        start_ok = start & ((state_q == S_IDLE) | (state_q == S_DONE));
        exp_val  = {1'b0, beat.in_a} + {1'b0, beat.in_b} + {{WIDTH{1'b0}}, beat.in_cin};
        got_val  = {beat.in_cout, beat.in_sum};
    end

`ifdef ADDER_CHECKER_STOP_ON_FAIL_EN
    // A mismatch reaching the counters closes the session; a beat taken on that same edge is dropped
    always_comb begin
        abort = stg_vld_q & stg_mis_q;
    end
`else
    // Sessions always run to in_last
    always_comb begin
        abort = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (accept & beat.in_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs; in_ready never looks at in_valid
    always_comb begin
        beat.in_ready = (state_q == S_RUN);
        busy          = (state_q == S_RUN) | (state_q == S_DRAIN);
        done          = (state_q == S_DONE);
        pass          = (state_q == S_DONE) & (fail_cnt_q == '0) & (pass_cnt_q != '0);
    end

    // Check stage next state: load on every accepted beat unless the session is being aborted
    always_comb begin
        stg_vld_d = accept & ~abort;
        stg_mis_d = (exp_val != got_val);
    end

    // Check stage registers; payload only moves on an accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld_q <= 1'b0;
            stg_mis_q <= 1'b0;
            stg_a_q   <= '0;
            stg_b_q   <= '0;
            stg_cin_q <= 1'b0;
            stg_exp_q <= '0;
            stg_got_q <= '0;
        end else begin
            stg_vld_q <= stg_vld_d;
            if (accept) begin
                stg_mis_q <= stg_mis_d;
                stg_a_q   <= beat.in_a;
                stg_b_q   <= beat.in_b;
                stg_cin_q <= beat.in_cin;
                stg_exp_q <= exp_val;
                stg_got_q <= got_val;
            end
        end
    end

    // Counter and error-capture next state: clear on session open, else retire the staged beat
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        err_vld_d  = err_vld_q;
        err_a_d    = err_a_q;
        err_b_d    = err_b_q;
        err_cin_d  = err_cin_q;
        err_exp_d  = err_exp_q;
        err_got_d  = err_got_q;
        if (start_ok) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            err_vld_d  = 1'b0;
            err_a_d    = '0;
            err_b_d    = '0;
            err_cin_d  = 1'b0;
            err_exp_d  = '0;
            err_got_d  = '0;
        end else if (stg_vld_q) begin
            if (stg_mis_q) begin
                if (fail_cnt_q != CNT_MAX) begin
                    fail_cnt_d = fail_cnt_q + 1'b1;
                end
                // Only the first mismatch of a session is kept for debug
                if (!err_vld_q) begin
                    err_vld_d = 1'b1;
                    err_a_d   = stg_a_q;
                    err_b_d   = stg_b_q;
                    err_cin_d = stg_cin_q;
                    err_exp_d = stg_exp_q;
                    err_got_d = stg_got_q;
                end
            end else if (pass_cnt_q != CNT_MAX) begin
                pass_cnt_d = pass_cnt_q + 1'b1;
            end
        end
    end

    // Counter and error-capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            err_vld_q  <= 1'b0;
            err_a_q    <= '0;
            err_b_q    <= '0;
            err_cin_q  <= 1'b0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            err_vld_q  <= err_vld_d;
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
            err_cin_q  <= err_cin_d;
            err_exp_q  <= err_exp_d;
            err_got_q  <= err_got_d;
        end
    end

    // Result outputs straight from registers
    always_comb begin
        pass_count = pass_cnt_q;
        fail_count = fail_cnt_q;
        err_valid  = err_vld_q;
        err_a      = err_a_q;
        err_b      = err_b_q;
        err_cin    = err_cin_q;
        err_exp    = err_exp_q;
        err_got    = err_got_q;
    end

endmodule

// File: tb/tb_adder_checker.sv
// Directed bench for adder_checker: a 16-bit-counter instance plus a 3-bit-counter twin on the same stream.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: beats are held until in_ready is seen high, bounded per beat.
module tb_adder_checker;

    localparam int W = 4;

    logic clk;
    logic rst;
    logic start;

    adder_checker_if #(.WIDTH(W)) ifc  ();
    adder_checker_if #(.WIDTH(W)) ifc3 ();

    logic        busy, done, pass, err_valid, err_cin;
    logic [15:0] pass_count, fail_count;
    logic [3:0]  err_a, err_b;
    logic [4:0]  err_exp, err_got;

    logic        busy3, done3, pass3, err_valid3, err_cin3;
    logic [2:0]  pass_count3, fail_count3;
    logic [3:0]  err_a3, err_b3;
    logic [4:0]  err_exp3, err_got3;

    int n_vec = 0;
    int n_err = 0;

    assign ifc3.in_valid = ifc.in_valid;
    assign ifc3.in_a     = ifc.in_a;
    assign ifc3.in_b     = ifc.in_b;
    assign ifc3.in_cin   = ifc.in_cin;
    assign ifc3.in_sum   = ifc.in_sum;
    assign ifc3.in_cout  = ifc.in_cout;
    assign ifc3.in_last  = ifc.in_last;

    adder_checker #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .beat(ifc),
        .busy(busy), .done(done), .pass(pass),
        .pass_count(pass_count), .fail_count(fail_count),
        .err_valid(err_valid), .err_a(err_a), .err_b(err_b), .err_cin(err_cin),
        .err_exp(err_exp), .err_got(err_got)
    );

    adder_checker #(.WIDTH(W), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .beat(ifc3),
        .busy(busy3), .done(done3), .pass(pass3),
        .pass_count(pass_count3), .fail_count(fail_count3),
        .err_valid(err_valid3), .err_a(err_a3), .err_b(err_b3), .err_cin(err_cin3),
        .err_exp(err_exp3), .err_got(err_got3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one beat and hold it until an edge where in_ready was high
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic [4:0] got, input logic last);
        bit acc;
        acc          = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_cin   = cin;
        ifc.in_cout  = got[4];
        ifc.in_sum   = got[3:0];
        ifc.in_last  = last;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = ifc.in_ready;
            tick();
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: beat %0h+%0h+%0h accepted=0 required=1", a, b, cin);
        end
    endtask

    initial begin
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [4:0] s;

        rst          = 1'b1;
        start        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_a     = '0;
        ifc.in_b     = '0;
        ifc.in_cin   = 1'b0;
        ifc.in_sum   = '0;
        ifc.in_cout  = 1'b0;
        ifc.in_last  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_in_ready",   ifc.in_ready, 0);
        check("rst_busy",       busy,         0);
        check("rst_done",       done,         0);
        check("rst_pass",       pass,         0);
        check("rst_pass_count", pass_count,   0);
        check("rst_fail_count", fail_count,   0);
        check("rst_err_valid",  err_valid,    0);
        check("rst_err_a",      err_a,        0);
        check("rst_err_exp",    err_exp,      0);
        check("rst_err_got",    err_got,      0);
        rst = 1'b0;
        tick();

        // Session 1: five good beats, last on the fifth
        pulse_start();
        check("s1_in_ready_after_start", ifc.in_ready, 1);
        check("s1_busy_after_start",     busy,         1);
        send(4'd5,  4'd3, 1'b0, 5'b01000, 1'b0);
        send(4'd7,  4'd8, 1'b0, 5'b01111, 1'b0);
        send(4'd15, 4'd1, 1'b0, 5'b10000, 1'b0);
        send(4'd0,  4'd0, 1'b1, 5'b00001, 1'b0);
        send(4'd10, 4'd6, 1'b0, 5'b10000, 1'b1);
        ifc.in_valid = 1'b0;
        check("s1_drain_done",     done,         0);
        check("s1_drain_in_ready", ifc.in_ready, 0);
        check("s1_drain_busy",     busy,         1);
        tick();
        check("s1_done",        done,        1);
        check("s1_busy",        busy,        0);
        check("s1_pass_count",  pass_count,  5);
        check("s1_fail_count",  fail_count,  0);
        check("s1_pass",        pass,        1);
        check("s1_err_valid",   err_valid,   0);
        check("s1_pass_count3", pass_count3, 5);

        // Beats offered while not ready are not consumed
        ifc.in_valid = 1'b1;
        ifc.in_a     = 4'd1;
        ifc.in_b     = 4'd1;
        ifc.in_sum   = 4'd0;
        ifc.in_cout  = 1'b0;
        ifc.in_last  = 1'b0;
        tick();
        tick();
        tick();
        ifc.in_valid = 1'b0;
        check("nrdy_pass_count", pass_count, 5);
        check("nrdy_fail_count", fail_count, 0);
        check("nrdy_done",       done,       1);

        // Session 2: mismatches
        pulse_start();
        check("s2_clr_pass_count", pass_count, 0);
        check("s2_clr_done",       done,       0);
        check("s2_clr_pass",       pass,       0);
`ifdef ADDER_CHECKER_STOP_ON_FAIL_EN
        send(4'd5,  4'd3, 1'b0, 5'b01000, 1'b0);
        send(4'd7,  4'd8, 1'b0, 5'b01110, 1'b0);
        send(4'd15, 4'd1, 1'b0, 5'b10000, 1'b0);
        ifc.in_valid = 1'b0;
        check("sf_done",       done,         1);
        check("sf_in_ready",   ifc.in_ready, 0);
        check("sf_fail_count", fail_count,   1);
        check("sf_pass_count", pass_count,   1);
        check("sf_pass",       pass,         0);
        check("sf_err_a",      err_a,        4'b0111);
        check("sf_err_got",    err_got,      5'b01110);
        tick();
        check("sf_pass_count_hold", pass_count, 1);
`else
        send(4'd5,  4'd3, 1'b0, 5'b01000, 1'b0);
        send(4'd7,  4'd8, 1'b0, 5'b01110, 1'b0);
        send(4'd15, 4'd1, 1'b0, 5'b10000, 1'b0);
        send(4'd2,  4'd2, 1'b0, 5'b00101, 1'b0);
        send(4'd0,  4'd0, 1'b1, 5'b00001, 1'b1);
        ifc.in_valid = 1'b0;
        tick();
        check("s2_done",       done,       1);
        check("s2_pass_count", pass_count, 3);
        check("s2_fail_count", fail_count, 2);
        check("s2_pass",       pass,       0);
        check("s2_err_valid",  err_valid,  1);
        check("s2_err_a",      err_a,      4'b0111);
        check("s2_err_b",      err_b,      4'b1000);
        check("s2_err_cin",    err_cin,    0);
        check("s2_err_exp",    err_exp,    5'b01111);
        check("s2_err_got",    err_got,    5'b01110);
`endif

        // Session 3: valid gaps and a start pulse during RUN
        pulse_start();
        send(4'd1, 4'd2, 1'b0, 5'b00011, 1'b0);
        ifc.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        check("s3_gap_pass_count", pass_count, 1);
        pulse_start();
        check("s3_start_ignored_count", pass_count,   1);
        check("s3_start_ignored_ready", ifc.in_ready, 1);
        send(4'd9, 4'd9, 1'b1, 5'b10011, 1'b0);
        ifc.in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        send(4'd15, 4'd15, 1'b1, 5'b11111, 1'b1);
        ifc.in_valid = 1'b0;
        tick();
        check("s3_done",       done,       1);
        check("s3_pass_count", pass_count, 3);
        check("s3_fail_count", fail_count, 0);
        check("s3_pass",       pass,       1);

        // Session 4: ten good beats, 3-bit counter saturates at 7
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            a = 4'(i);
            b = 4'(i + 3);
            c = a[0];
            s = {1'b0, a} + {1'b0, b} + {4'b0000, c};
            send(a, b, c, s, (i == 9));
        end
        ifc.in_valid = 1'b0;
        tick();
        check("s4_pass_count",  pass_count,  10);
        check("s4_pass_count3", pass_count3, 7);
        check("s4_done3",       done3,       1);
        check("s4_pass3",       pass3,       1);
        pulse_start();
        check("s4_restart_count3", pass_count3, 0);
        check("s4_restart_count",  pass_count,  0);
        check("s4_restart_done",   done,        0);

        // Session 5: reset after two beats
        send(4'd3, 4'd4, 1'b0, 5'b00111, 1'b0);
        send(4'd6, 4'd6, 1'b0, 5'b01100, 1'b0);
        check("s5_pre_rst_count", pass_count, 1);
        rst          = 1'b1;
        ifc.in_valid = 1'b0;
        tick();
        check("s5_rst_in_ready",   ifc.in_ready, 0);
        check("s5_rst_busy",       busy,         0);
        check("s5_rst_done",       done,         0);
        check("s5_rst_pass_count", pass_count,   0);
        check("s5_rst_count3",     pass_count3,  0);
        check("s5_rst_err_valid",  err_valid,    0);
        rst = 1'b0;
        tick();
        check("s5_idle_in_ready", ifc.in_ready, 0);
        pulse_start();
        send(4'd8, 4'd8, 1'b0, 5'b10000, 1'b1);
        ifc.in_valid = 1'b0;
        tick();
        check("s5_done",       done,       1);
        check("s5_pass_count", pass_count, 1);
        check("s5_pass",       pass,       1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
